// File: rtl/fetch_stage_p_if.sv
`default_nettype none
// ============================================================================
// Module  : fetch_stage_p_if
// Purpose : Instruction-memory bus and stage-register handshake bundle for
//           the fetch stage. The master side is the fetch stage itself; the
//           slave side is the instruction memory plus the downstream stage.
// Revision: 1.0 - initial release
// ============================================================================
interface fetch_stage_p_if #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 8,
  parameter int OP_W   = 5,
  parameter int MODE_W = 3
);
  // instruction memory side
  logic [PC_W-1:0]   imem_addr;
  logic              imem_rd;
  logic [DATA_W-1:0] imem_rdata;

  // stage register side
  logic              next_ready;
  logic [OP_W-1:0]   StageRegInstr_out;
  logic [MODE_W-1:0] StageRegAddrMode_out;
  logic [DATA_W-1:0] StageRegData_out;
  logic              FirstStageComplete;

  modport master (
    output imem_addr,
    output imem_rd,
    input  imem_rdata,
    input  next_ready,
    output StageRegInstr_out,
    output StageRegAddrMode_out,
    output StageRegData_out,
    output FirstStageComplete
  );

  modport slave (
    input  imem_addr,
    input  imem_rd,
    output imem_rdata,
    output next_ready,
    input  StageRegInstr_out,
    input  StageRegAddrMode_out,
    input  StageRegData_out,
    input  FirstStageComplete
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage_p.sv
`default_nettype none
// ============================================================================
// Module  : fetch_stage_p
// Purpose : First pipeline stage. Fetches a one- or two-word instruction
//           from instruction memory (opcode/mode word, optional operand
//           word), presents it in a stage register with a valid/ready
//           handshake, handles HLT, and optionally interrupt entry and RTI.
// Options : FETCH_STAGE_INT_EN - when defined, the INT state, saved PC and
//           interrupt mask exist and RTI_OP restores the saved PC. When
//           undefined, interrupt is ignored, int_ack is 0 and RTI_OP is an
//           ordinary opcode.
// Assumes : OP_W + MODE_W <= DATA_W, PC_W >= 2.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_stage_p #(
  parameter int              PC_W       = 8,
  parameter int              DATA_W     = 8,
  parameter int              OP_W       = 5,
  parameter int              MODE_W     = 3,
  parameter logic [PC_W-1:0] INT_VECTOR = 8'hF0,
  parameter logic [OP_W-1:0] RTI_OP     = 5'h1E,
  parameter logic [OP_W-1:0] HLT_OP     = 5'h1F
) (
  input  wire                  clk,
  input  wire                  reset,
  input  wire                  StartEverything,
  input  wire     [PC_W-1:0]   ProCounterin,
  input  wire                  interrupt,
  fetch_stage_p_if.master      bus,
  output logic                 int_ack,
  output logic    [PC_W-1:0]   pc_out,
  output logic                 halted
);

  // state encoding
  localparam logic [2:0] c_stIdle  = 3'd0;
  localparam logic [2:0] c_stFOp   = 3'd1;
  localparam logic [2:0] c_stWOp   = 3'd2;
  localparam logic [2:0] c_stFDat  = 3'd3;
  localparam logic [2:0] c_stWDat  = 3'd4;
  localparam logic [2:0] c_stValid = 3'd5;
`ifdef FETCH_STAGE_INT_EN
  localparam logic [2:0] c_stInt   = 3'd6;
`endif

  localparam logic [PC_W-1:0] c_pcOne = PC_W'(1);

  logic [2:0]        r_state;
  logic [PC_W-1:0]   r_pc;
  logic [OP_W-1:0]   r_instr;
  logic [MODE_W-1:0] r_mode;
  logic [DATA_W-1:0] r_data;
  logic              r_halted;

  logic [2:0]        w_nextState;
  logic [PC_W-1:0]   w_nextPc;
  logic [OP_W-1:0]   w_nextInstr;
  logic [MODE_W-1:0] w_nextMode;
  logic [DATA_W-1:0] w_nextData;
  logic              w_nextHalted;

  // opcode/mode fields of the word returned for the current fetch
  logic [OP_W-1:0]   w_rdOp;
  logic [MODE_W-1:0] w_rdMode;

`ifdef FETCH_STAGE_INT_EN
  logic [PC_W-1:0]   r_savedPc;
  logic              r_intMask;
  logic [PC_W-1:0]   w_nextSavedPc;
  logic              w_nextIntMask;
`else
  // interrupt path absent: keep the otherwise unreferenced items tied off
  logic              w_unused;
  assign w_unused = ^{interrupt, RTI_OP, INT_VECTOR};
`endif

  assign w_rdOp   = bus.imem_rdata[DATA_W-1 -: OP_W];
  assign w_rdMode = bus.imem_rdata[MODE_W-1:0];

  // next-state and next-register computation for the fetch sequencer
  always_comb begin
    w_nextState  = r_state;
    w_nextPc     = r_pc;
    w_nextInstr  = r_instr;
    w_nextMode   = r_mode;
    w_nextData   = r_data;
    w_nextHalted = r_halted;
`ifdef FETCH_STAGE_INT_EN
    w_nextSavedPc = r_savedPc;
    w_nextIntMask = r_intMask;
`endif
    case (r_state)
      c_stIdle: begin
        // a start pulse is only honoured here; elsewhere it is ignored
        if (StartEverything) begin
          w_nextPc     = ProCounterin;
          w_nextHalted = 1'b0;
          w_nextState  = c_stFOp;
        end
      end
      c_stFOp: begin
        w_nextState = c_stWOp;
      end
      c_stWOp: begin
        w_nextInstr = w_rdOp;
        w_nextMode  = w_rdMode;
        w_nextPc    = r_pc + c_pcOne;
        // mode zero means no operand word follows
        if (w_rdMode == '0) begin
          w_nextData  = '0;
          w_nextState = c_stValid;
        end else begin
          w_nextState = c_stFDat;
        end
      end
      c_stFDat: begin
        w_nextState = c_stWDat;
      end
      c_stWDat: begin
        w_nextData  = bus.imem_rdata;
        w_nextPc    = r_pc + c_pcOne;
        w_nextState = c_stValid;
      end
      c_stValid: begin
        // everything below happens only on the handshake cycle
        if (bus.next_ready) begin
          if (r_instr == HLT_OP) begin
            w_nextHalted = 1'b1;
            w_nextState  = c_stIdle;
          end
`ifdef FETCH_STAGE_INT_EN
          else if (r_instr == RTI_OP) begin
            w_nextPc      = r_savedPc;
            w_nextIntMask = 1'b0;
            w_nextState   = c_stFOp;
          end else if (interrupt && !r_intMask) begin
            w_nextState = c_stInt;
          end
`endif
          else begin
            w_nextState = c_stFOp;
          end
        end
      end
`ifdef FETCH_STAGE_INT_EN
      c_stInt: begin
        // PC already points past the last accepted instruction
        w_nextSavedPc = r_pc;
        w_nextPc      = INT_VECTOR;
        w_nextIntMask = 1'b1;
        w_nextState   = c_stFOp;
      end
`endif
      default: begin
        w_nextState = c_stIdle;
      end
    endcase
  end

  // state and stage registers; reset discards any in-flight fetch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= c_stIdle;
      r_pc     <= '0;
      r_instr  <= '0;
      r_mode   <= '0;
      r_data   <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_pc     <= w_nextPc;
      r_instr  <= w_nextInstr;
      r_mode   <= w_nextMode;
      r_data   <= w_nextData;
      r_halted <= w_nextHalted;
    end
  end

`ifdef FETCH_STAGE_INT_EN
  // interrupt return address and nesting mask
  always_ff @(posedge clk) begin
    if (reset) begin
      r_savedPc <= '0;
      r_intMask <= 1'b0;
    end else begin
      r_savedPc <= w_nextSavedPc;
      r_intMask <= w_nextIntMask;
    end
  end

  assign int_ack = (r_state == c_stInt);
`else
  assign int_ack = 1'b0;
`endif

  // memory strobe only in the two fetch-issue states; address always tracks PC
  assign bus.imem_rd   = (r_state == c_stFOp) || (r_state == c_stFDat);
  assign bus.imem_addr = r_pc;

  assign bus.StageRegInstr_out    = r_instr;
  assign bus.StageRegAddrMode_out = r_mode;
  assign bus.StageRegData_out     = r_data;
  assign bus.FirstStageComplete   = (r_state == c_stValid);

  assign pc_out = r_pc;
  assign halted = r_halted;

endmodule
`default_nettype wire
